sseg_scan_decoder: RTL and testbench

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

---
 rtl/sseg_pkg.sv | 23 ++
 rtl/sseg_to_hex.sv | 23 ++
 rtl/sseg_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: hex segment codes, blank code and capture FSM states.
// Used by the scan decoder and by any hex-to-segment encoder.
package sseg_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'h00;

  // Element i is the active-high a..g pattern for hex digit i.
  localparam logic [15:0][6:0] SSEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_CAPTURED
  } cap_state_t;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nibble);
    return SSEG_CODES[nibble];
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational exact-match decode of a seven-segment pattern back to a hex nibble.
module sseg_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] i_sseg,
  output logic [3:0] o_nibble,
  output logic       o_hit,
  output logic       o_blank
);

  always_comb begin
    o_nibble = '0;
    o_hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_sseg == SSEG_CODES[i]) begin
        o_nibble = 4'(i);
        o_hit    = 1'b1;
      end
    end
    o_blank = (i_sseg == SSEG_BLANK);
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment scan and offers full frames with valid/ready.
// Optional saturating error counter enabled by defining SSEG_DEC_ERR_CNT_EN.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_DIGITS-1:0]   i_an,
  input  logic [6:0]              i_sseg,
  output logic [4*NUM_DIGITS-1:0] o_frame,
  output logic                    o_frame_valid,
  input  logic                    i_frame_ready,
  output logic                    o_err,
  output logic [7:0]              o_err_cnt
);

  cap_state_t                  state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]       an_prev_q, an_prev_d;
  logic [6:0]                  sseg_prev_q, sseg_prev_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0]  digit_q, digit_d;
  logic [NUM_DIGITS-1:0][3:0]  frame_q, frame_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;

  logic [3:0] dec_nibble;
  logic       dec_hit;
  logic       dec_blank;
  logic       an_onehot;
  logic       in_changed;
  logic       capture;
  logic       load;

  sseg_to_hex u_dec (
    .i_sseg   (i_sseg),
    .o_nibble (dec_nibble),
    .o_hit    (dec_hit),
    .o_blank  (dec_blank)
  );

  // Stability tracking: any input change restarts the window; one capture per window.
  always_comb begin
    an_onehot  = (i_an != '0) && ((i_an & (i_an - NUM_DIGITS'(1))) == '0);
    in_changed = (i_an != an_prev_q) || (i_sseg != sseg_prev_q);
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (an_onehot) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!an_onehot) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (in_changed) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
        end else if (state_q == ST_TRACK) begin
          if (cnt_q == 8'(STABLE_CYCLES - 1)) begin
            state_d = ST_CAPTURED;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  // A load snapshots the pre-capture digits; a same-cycle capture lands in the next frame's mask.
  always_comb begin
    load        = (&mask_q) && !valid_q;
    mask_d      = load ? '0 : mask_q;
    digit_d     = digit_q;
    frame_d     = frame_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    an_prev_d   = i_an;
    sseg_prev_d = i_sseg;
    if (load) begin
      frame_d = digit_q;
      valid_d = 1'b1;
    end else if (valid_q && i_frame_ready) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      if (dec_hit) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (i_an[k]) begin
            digit_d[k] = dec_nibble;
            mask_d[k]  = 1'b1;
          end
        end
      end else if (!dec_blank) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      an_prev_q   <= '0;
      sseg_prev_q <= '0;
      mask_q      <= '0;
      digit_q     <= '0;
      frame_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      an_prev_q   <= an_prev_d;
      sseg_prev_q <= sseg_prev_d;
      mask_q      <= mask_d;
      digit_q     <= digit_d;
      frame_q     <= frame_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign o_frame       = frame_q;
  assign o_frame_valid = valid_q;
  assign o_err         = err_q;

`ifdef SSEG_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed self-checking bench for sseg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_sseg_scan_decoder;

  localparam int EXP_ERR_CNT =
`ifdef SSEG_DEC_ERR_CNT_EN
    1;
`else
    0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = '0;
  logic [6:0]  sseg = '0;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        err;
  logic [7:0]  err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_cycles   = 0;

  sseg_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_an          (an),
    .i_sseg        (sseg),
    .o_frame       (frame),
    .o_frame_valid (frame_valid),
    .i_frame_ready (frame_ready),
    .o_err         (err),
    .o_err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Count every cycle o_err is seen high, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && err) err_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Hold an anode/segment pair for n rising edges, returning 1ns after the last one.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReady();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    #3;
    checkOutput("reset_frame", 32'(frame), 32'h0);
    checkOutput("reset_valid", 32'(frame_valid), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic scan 0..3
    applyStimulus(4'b0001, 7'h3F, 10);
    applyStimulus(4'b0010, 7'h06, 10);
    applyStimulus(4'b0100, 7'h5B, 10);
    applyStimulus(4'b1000, 7'h4F, 10);
    checkOutput("scan_valid", 32'(frame_valid), 32'h1);
    checkOutput("scan_frame", 32'(frame), 32'h3210);
    applyStimulus(4'b0000, 7'h00, 1);
    pulseReady();
    checkOutput("scan_valid_cleared", 32'(frame_valid), 32'h0);
    checkOutput("scan_frame_held", 32'(frame), 32'h3210);

    // Digit 0 never stable for 8 cycles, then digits 1..3 captured: mask not full
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0001, (i % 2 == 0) ? 7'h3F : 7'h06, 4);
    end
    applyStimulus(4'b0010, 7'h66, 10);
    applyStimulus(4'b0100, 7'h6D, 10);
    applyStimulus(4'b1000, 7'h7D, 10);
    checkOutput("toggle_no_frame", 32'(frame_valid), 32'h0);
    checkOutput("toggle_no_err", 32'(err_cycles), 32'h0);

    // Unrecognised stable pattern on digit 0
    applyStimulus(4'b0001, 7'h2A, 10);
    checkOutput("bad_err_one_cycle", 32'(err_cycles), 32'h1);
    checkOutput("bad_no_frame", 32'(frame_valid), 32'h0);
    checkOutput("bad_err_cnt", 32'(err_cnt), 32'(EXP_ERR_CNT));
    applyStimulus(4'b0001, 7'h7F, 10);
    checkOutput("bad_then_good_valid", 32'(frame_valid), 32'h1);
    checkOutput("bad_then_good_frame", 32'(frame), 32'h6548);

    // Second full scan while the frame is pending
    applyStimulus(4'b0001, 7'h77, 10);
    applyStimulus(4'b0010, 7'h7C, 10);
    applyStimulus(4'b0100, 7'h39, 10);
    applyStimulus(4'b1000, 7'h5E, 10);
    checkOutput("pending_frame_held", 32'(frame), 32'h6548);
    checkOutput("pending_valid_held", 32'(frame_valid), 32'h1);
    applyStimulus(4'b0000, 7'h00, 1);
    pulseReady();
    checkOutput("bubble_valid_low", 32'(frame_valid), 32'h0);
    applyStimulus(4'b0000, 7'h00, 1);
    checkOutput("next_valid", 32'(frame_valid), 32'h1);
    checkOutput("next_frame", 32'(frame), 32'hDCBA);
    pulseReady();
    applyStimulus(4'b0000, 7'h00, 2);
    checkOutput("drained_valid", 32'(frame_valid), 32'h0);

    // Multi-hot anodes: no capture, no error
    applyStimulus(4'b0011, 7'h3F, 10);
    applyStimulus(4'b0100, 7'h5B, 10);
    applyStimulus(4'b1000, 7'h4F, 10);
    checkOutput("multihot_no_frame", 32'(frame_valid), 32'h0);
    checkOutput("multihot_no_err", 32'(err_cycles), 32'h1);

    // Digits 0..1 complete the mask; then reset mid-cycle
    applyStimulus(4'b0001, 7'h3F, 10);
    applyStimulus(4'b0010, 7'h06, 10);
    checkOutput("prereset_valid", 32'(frame_valid), 32'h1);
    checkOutput("prereset_frame", 32'(frame), 32'h3210);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_frame", 32'(frame), 32'h0);
    checkOutput("rst_valid", 32'(frame_valid), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(4'b0100, 7'h6F, 10);
    applyStimulus(4'b1000, 7'h07, 10);
    checkOutput("postrst_partial", 32'(frame_valid), 32'h0);
    applyStimulus(4'b0001, 7'h3F, 10);
    applyStimulus(4'b0010, 7'h06, 10);
    checkOutput("postrst_valid", 32'(frame_valid), 32'h1);
    checkOutput("postrst_frame", 32'(frame), 32'h7910);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
